// File: rtl/prog_instruction_memory.sv
// Field-loadable instruction memory: registered fetch port plus a byte-stream program loader.
// Define IMEM_PARITY_EN to store and check one even-parity bit per word.
module prog_instruction_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  stall,
  input  logic                  load_req,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [ADDR_WIDTH:0]   load_count,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  load_done,
  output logic                  load_error,
  input  logic                  parity_inject,
  output logic                  parity_error
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(BYTES) + 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_CNT   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [IDX_W-1:0]      ONE_IDX   = IDX_W'(1);

  typedef enum logic [1:0] {IDLE, ASSEMBLE, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic                    load_error_q, load_error_d;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign stall       = (state_q != IDLE);
  assign byte_ready  = (state_q == ASSEMBLE);
  assign load_done   = (state_q == DONE);
  assign load_error  = load_error_q;
  assign instruction = instr_q;
  assign rd_word     = mem[fetch_addr];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    idx_d        = idx_q;
    word_d       = word_q;
    load_error_d = 1'b0;
    mem_we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_req) begin
          if (load_count == '0 || load_count > DEPTH_CNT) begin
            load_error_d = 1'b1;
          end else begin
            addr_d  = load_addr;
            count_d = load_count;
            idx_d   = '0;
            state_d = ASSEMBLE;
          end
        end
      end
      ASSEMBLE: begin
        if (byte_valid) begin
          // Shift left so the first byte of a word ends up in the top byte lane.
          word_d = (word_q << 8) | DATA_WIDTH'(byte_data);
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = WRITE;
          end else begin
            idx_d = idx_q + ONE_IDX;
          end
        end
      end
      WRITE: begin
        mem_we  = 1'b1;
        addr_d  = addr_q + ONE_ADDR;
        count_d = count_q - ONE_CNT;
        state_d = (count_q == ONE_CNT) ? DONE : ASSEMBLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    if (stall)         instr_d = '0;
    else if (fetch_en) instr_d = rd_word;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      instr_q      <= '0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      instr_q      <= instr_d;
      load_error_q <= load_error_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM and keeps its program across a reset.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[addr_q] <= word_q;
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_err_q, par_err_d;

  always_ff @(posedge clock) begin
    if (mem_we && !reset) par_mem[addr_q] <= (^word_q) ^ parity_inject;
  end

  always_comb begin
    par_err_d = par_err_q;
    if (stall)         par_err_d = 1'b0;
    else if (fetch_en) par_err_d = (^rd_word) != par_mem[fetch_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) par_err_q <= 1'b0;
    else       par_err_q <= par_err_d;
  end

  assign parity_error = par_err_q;
`else
  logic unused_parity_inject;
  assign unused_parity_inject = parity_inject;
  assign parity_error         = 1'b0;
`endif

endmodule

// File: tb/tb_prog_instruction_memory.sv
// Self-checking bench for prog_instruction_memory: directed scenarios plus random loads
// checked against a word-level reference memory.
module tb_prog_instruction_memory;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 256;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_en = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [DW-1:0] instruction;
  logic          stall;
  logic          load_req = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [AW:0]   load_count = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready;
  logic          load_done;
  logic          load_error;
  logic          parity_inject = 1'b0;
  logic          parity_error;

  int n_cmp = 0;
  int n_mis = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic          ref_inj [DEPTH];
  logic [7:0]    byte_q [$];

  prog_instruction_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .instruction(instruction), .stall(stall), .load_req(load_req), .load_addr(load_addr),
    .load_count(load_count), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .load_done(load_done), .load_error(load_error),
    .parity_inject(parity_inject), .parity_error(parity_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic exp_par(input logic [AW-1:0] a);
`ifdef IMEM_PARITY_EN
    return ref_inj[a];
`else
    return 1'b0;
`endif
  endfunction

  task automatic fill_random(input int n);
    byte_q.delete();
    for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"}, instruction, 0);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_ready"}, byte_ready, 0);
    check({tag, "_done"}, load_done, 0);
    check({tag, "_err"}, load_error, 0);
    check({tag, "_par"}, parity_error, 0);
  endtask

  // Runs a whole load from byte_q; exp_cycles > 0 also checks load_req-to-stall-low time.
  task automatic run_load(input logic [AW-1:0] addr, input int cnt, input bit gaps,
                          input bit inj, input int exp_cycles);
    int  idx = 0;
    int  cycles;
    int  budget = 0;
    bit  done_seen = 1'b0;
    bit  first = 1'b1;
    logic [AW-1:0] a;
    load_addr     = addr;
    load_count    = (AW + 1)'(cnt);
    load_req      = 1'b1;
    parity_inject = inj;
    fetch_en      = 1'b0;
    tick();
    cycles = 1;
    check("stall_rise", stall, 1);
    while (stall === 1'b1 && budget < 2000) begin
      load_req   = 1'($urandom);
      load_count = '0;
      byte_valid = (idx < byte_q.size()) && (!gaps || $urandom_range(0, 2) != 0);
      byte_data  = byte_valid ? byte_q[idx] : 8'($urandom);
      fetch_en   = 1'($urandom);
      fetch_addr = AW'($urandom);
      check("busy_no_err", load_error, 0);
      if (!first) begin
        check("nop_in_load", instruction, 0);
        check("par_in_load", parity_error, 0);
      end
      first = 1'b0;
      if (load_done === 1'b1) done_seen = 1'b1;
      if (byte_valid && byte_ready === 1'b1) idx++;
      tick();
      cycles++;
      budget++;
    end
    load_req   = 1'b0;
    byte_valid = 1'b0;
    fetch_en   = 1'b0;
    check("stall_fell", stall, 0);
    check("load_done_seen", done_seen, 1);
    check("load_done_low", load_done, 0);
    check("bytes_used", idx, cnt * 4);
    if (exp_cycles > 0) check("load_cycles", cycles, exp_cycles);
    for (int w = 0; w < cnt; w++) begin
      a = AW'(int'(addr) + w);
      ref_mem[a] = {byte_q[4*w], byte_q[4*w+1], byte_q[4*w+2], byte_q[4*w+3]};
      ref_inj[a] = inj;
    end
  endtask

  task automatic fetch_check(input logic [AW-1:0] a);
    fetch_en   = 1'b1;
    fetch_addr = a;
    tick();
    fetch_en   = 1'b0;
    fetch_addr = AW'($urandom);
    check("fetch_data", instruction, ref_mem[a]);
    check("fetch_par", parity_error, exp_par(a));
    tick();
    check("fetch_hold", instruction, ref_mem[a]);
  endtask

  task automatic reject(input logic [AW:0] cnt);
    load_addr  = AW'($urandom);
    load_count = cnt;
    load_req   = 1'b1;
    tick();
    load_req = 1'b0;
    check("rej_err_pulse", load_error, 1);
    check("rej_stall", stall, 0);
    check("rej_ready", byte_ready, 0);
    tick();
    check("rej_err_clear", load_error, 0);
    check("rej_stall2", stall, 0);
  endtask

  initial begin
    int idx;
    int budget;
    int cnt;
    logic [AW-1:0] a;

    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();
    check_reset_outputs("post_reset");

    // Directed two-word load from the bring-up sequence.
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(8'd0, 2, 1'b0, 1'b0, 12);
    fetch_check(8'd0);
    check("tp_word0", instruction, 32'h1122_3344);
    fetch_check(8'd1);
    check("tp_word1", instruction, 32'h5566_7788);

    // Rejected requests leave memory alone.
    reject(9'd0);
    reject(9'd257);
    reject(9'($urandom_range(258, 511)));
    fetch_check(8'd0);
    fetch_check(8'd1);

    // Wrap past the top word.
    fill_random(8);
    run_load(8'd255, 2, 1'b0, 1'b0, 12);
    fetch_check(8'd255);
    fetch_check(8'd0);

    // Irregular byte_valid gaps.
    fill_random(12);
    run_load(8'd20, 3, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) fetch_check(AW'(20 + i));

    // Reset two bytes into the second word of a load.
    fill_random(8);
    run_load(8'd40, 2, 1'b0, 1'b0, 12);
    fill_random(8);
    load_addr  = 8'd40;
    load_count = 9'd2;
    load_req   = 1'b1;
    tick();
    load_req = 1'b0;
    idx      = 0;
    budget   = 0;
    while (idx < 6 && budget < 100) begin
      byte_valid = 1'b1;
      byte_data  = byte_q[idx];
      if (byte_ready === 1'b1) idx++;
      tick();
      budget++;
    end
    byte_valid = 1'b0;
    check("abort_bytes", idx, 6);
    reset = 1'b1;
    tick();
    check_reset_outputs("abort_reset");
    reset = 1'b0;
    tick();
    check_reset_outputs("abort_idle");
    ref_mem[40] = {byte_q[0], byte_q[1], byte_q[2], byte_q[3]};
    ref_inj[40] = 1'b0;
    fetch_check(8'd40);
    fetch_check(8'd41);

    // Parity inject, then clean reload of the same word.
    fill_random(4);
    run_load(8'd60, 1, 1'b0, 1'b1, 7);
    fetch_check(8'd60);
    fill_random(4);
    run_load(8'd60, 1, 1'b0, 1'b0, 7);
    fetch_check(8'd60);

    // Random loads.
    for (int n = 0; n < 6; n++) begin
      cnt = $urandom_range(1, 5);
      a   = AW'($urandom);
      fill_random(cnt * 4);
      run_load(a, cnt, 1'($urandom), 1'($urandom), 0);
      for (int w = 0; w < cnt; w++) fetch_check(AW'(int'(a) + w));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
